// File: rtl/button_pkg.sv
// button_pkg: shared types and limits for the button event block.
// Holds the FSM state enum and minimum-parameter constants.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_t;

  localparam int unsigned MIN_LONG_CYCLES   = 2;
  localparam int unsigned MIN_REPEAT_CYCLES = 2;

  // True when a w-bit unsigned counter can hold v.
  function automatic bit cnt_fits(
    input int unsigned w,
    input int unsigned v
  );
    return (64'd1 << w) > 64'(v);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input.
// RST_VAL is loaded into both flops so reset yields a quiet level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_event.sv
// button_event: press/release/long-press/repeat pulses from a button level.
// Repeat path is built only when BUTTON_REPEAT_EN is defined.
module button_event
  import button_pkg::*;
#(
  parameter bit          ACTIVE_LOW    = 1'b0,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic signal,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  if (LONG_CYCLES < MIN_LONG_CYCLES) begin : g_bad_long
    $error("LONG_CYCLES below minimum");
  end
  if (REPEAT_CYCLES < MIN_REPEAT_CYCLES) begin : g_bad_rep
    $error("REPEAT_CYCLES below minimum");
  end
  if (!cnt_fits(CNT_W, LONG_CYCLES)) begin : g_bad_wl
    $error("CNT_W too narrow for LONG_CYCLES");
  end
  if (!cnt_fits(CNT_W, REPEAT_CYCLES)) begin : g_bad_wr
    $error("CNT_W too narrow for REPEAT_CYCLES");
  end

  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             sync_q;
  logic             lvl;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_d, rel_d, long_d, rep_d;

  sync_2ff #(
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (signal),
    .q     (sync_q)
  );

  assign lvl = sync_q ^ ACTIVE_LOW;

  // Next state, hold counter and event pulses; release beats thresholds.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lvl) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (!lvl) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else if (cnt_q == LONG_M1) begin
          state_d = LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LONG: begin
        if (!lvl) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else begin
`ifdef BUTTON_REPEAT_EN
          if (cnt_q == REP_M1) begin
            cnt_d = '0;
            rep_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Register state, counter and all outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      press         <= press_d;
      release_pulse <= rel_d;
      long_press    <= long_d;
      repeat_pulse  <= rep_d;
      held          <= (state_d != IDLE);
    end
  end

endmodule
